bus_dma: RTL
============

Name: bus_dma

Overview:
Bus initiator that copies a block of 32-bit words from a source address to a destination address over the MemSplit32 split-transaction bus. It is the requester-side counterpart of the CPU-facing CSR/accelerator responders. It lets operand and result arrays move between memory and accelerator register windows without the CPU issuing every access. Control comes from a local CSR block as start/address/length ports; the bus side connects to an xif/hif-style fabric port.

Parameters:
LEN_WIDTH, 16, width of the word-count field; maximum transfer is 2**LEN_WIDTH-1 words.
RESP_TIMEOUT, 1024, cycles to wait in RD_WAIT for a read response before aborting with error.

Ports:
clk_i  in  1  clock
arst_n_i  in  1  asynchronous active-low reset
start_i  in  1  one-cycle start pulse; sampled only in IDLE
src_addr_i  in  32  source byte address, word aligned; bits [1:0] ignored and treated as 0
dst_addr_i  in  32  destination byte address, word aligned; bits [1:0] ignored and treated as 0
len_i  in  LEN_WIDTH  number of words to copy
busy_o  out  1  high from the cycle after an accepted start until done_o
done_o  out  1  one-cycle pulse at end of transfer (success or error)
err_o  out  1  sticky read-timeout flag; cleared by the next accepted start
words_done_o  out  LEN_WIDTH  count of words written so far in the current or last transfer
bus_req_o  out  1  request valid
bus_we_o  out  1  1 = write, 0 = read
bus_addr_bo  out  32  request address
bus_be_bo  out  4  byte enables, always 4'hF while bus_req_o is high
bus_wdata_bo  out  32  write data
bus_ack_i  in  1  request accepted in this cycle when bus_req_o is also high
bus_resp_i  in  1  read data valid, arrives at least 1 cycle after read ack
bus_rdata_bi  in  32  read data

Behaviour:
- Reset (arst_n_i=0, async): state IDLE; all outputs 0, including bus_* and words_done_o; internal address/count registers 0. Reset mid-transfer drops bus_req_o immediately; no done_o is generated.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH.
- IDLE, start_i=1, len_i≠0:
  - latch src, dst, len; clear err_o and words_done_o; busy_o=1.
  - go to RD_REQ next cycle.
- IDLE, start_i=1, len_i=0: clear err_o and words_done_o; go to FINISH; no bus traffic.
- start_i outside IDLE is ignored; latched values do not change.
- RD_REQ:
  - bus_req_o=1, we=0, addr=current src.
  - Hold all bus_* stable until the cycle with bus_ack_i=1.
  - On ack, go to RD_WAIT and clear the timeout counter.
- RD_WAIT:
  - bus_req_o=0.
  - On bus_resp_i=1: capture bus_rdata_bi into the write-data register and go to WR_REQ.
  - A bus_resp_i in any other state is ignored.
  - If the counter reaches RESP_TIMEOUT without resp: set err_o and go to FINISH.
- WR_REQ:
  - bus_req_o=1, we=1, addr=current dst, wdata=captured word.
  - Hold stable until ack.
  - On ack: words_done_o+1, src+4, dst+4, remaining-1.
  - If remaining was 1, go to FINISH; else go to RD_REQ.
- Address increments are modulo 2**32 (wrap from 32'hFFFFFFFC to 0 with no error).
- FINISH: done_o=1 for exactly one cycle; busy_o=0 in that cycle; next state IDLE. A new start can be accepted the cycle after FINISH.
- Only one bus transaction is outstanding at any time.
- Minimum latency per word with zero-wait ack and resp 1 cycle after ack: 3 cycles (RD_REQ, RD_WAIT, WR_REQ).
- bus_wdata_bo is 0 whenever bus_we_o=0. bus_be_bo=0 when bus_req_o=0.

Decomposition:
- Package bus_dma_pkg:
  - state enum dma_state_t
  - BE_FULL=4'hF
  - WORD_BYTES=32'd4
- Timeout counter is a small sub-module, bus_dma_timeout:
  - clear/enable inputs, expired output, parameterised by RESP_TIMEOUT.
- All other logic stays in one FSM module.

Test Plan:
- Copy, len=4, src=32'h0000_1000, dst=32'hC000_0008, ack same cycle as req, resp 1 cycle later -> reads 0x1000..0x100C then writes 0xC0000008..0xC0000014 in interleaved order; data matches; words_done_o=4; one done_o; err_o=0; 12 busy cycles.
- len=0 start -> done_o one cycle later; bus_req_o never asserted; words_done_o=0.
- Ack back-pressure of 3 cycles on every request -> bus_addr_bo, bus_we_o and bus_wdata_bo stay stable across the waits; data copied correctly.
- RESP_TIMEOUT=16, responder never asserts resp -> err_o=1 and done_o exactly 17 cycles after the read ack; no write issued; the next start clears err_o.
- start_i pulsed while busy with different src -> ignored; the original transfer completes unchanged. Also: src=32'hFFFF_FFFC, len=2 -> second read at 32'h0000_0000.
- Assert arst_n_i low during WR_REQ of word 2 of 4 -> bus_req_o falls asynchronously; all outputs 0; no done_o; a fresh start after release works normally.

Source files
------------

// File: rtl/bus_dma_pkg.sv
// Shared types and constants for the bus_dma block-copy initiator.
package bus_dma_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    FINISH  = 3'd4
  } dma_state_t;

  localparam logic [3:0]  BE_FULL    = 4'hF;
  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/bus_dma_timeout.sv
// Read-response watchdog: counts RD_WAIT cycles, flags expiry on the last allowed one.
module bus_dma_timeout #(
  parameter int RESP_TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(RESP_TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // Expiry is raised while the RESP_TIMEOUT-th wait cycle is in progress.
  assign expired_o = en_i && (cnt_q == CW'(RESP_TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)                cnt_q <= '0;
    else if (clr_i)               cnt_q <= '0;
    else if (en_i && !expired_o)  cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/bus_dma.sv
// Word-copy DMA initiator on the MemSplit32 bus: read one word, write it, repeat.
module bus_dma
  import bus_dma_pkg::*;
#(
  parameter int LEN_WIDTH    = 16,
  parameter int RESP_TIMEOUT = 1024
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic                 start_i,
  input  logic [31:0]          src_addr_i,
  input  logic [31:0]          dst_addr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [LEN_WIDTH-1:0] words_done_o,
  output logic                 bus_req_o,
  output logic                 bus_we_o,
  output logic [31:0]          bus_addr_bo,
  output logic [3:0]           bus_be_bo,
  output logic [31:0]          bus_wdata_bo,
  input  logic                 bus_ack_i,
  input  logic                 bus_resp_i,
  input  logic [31:0]          bus_rdata_bi
);

  dma_state_t           state_q;
  logic [31:0]          src_q, dst_q, addr_q, wdata_q;
  logic [LEN_WIDTH-1:0] rem_q, words_q;
  logic                 busy_q, done_q, err_q, req_q, we_q;
  logic [3:0]           be_q;
  logic                 tmo_expired;

  bus_dma_timeout #(.RESP_TIMEOUT(RESP_TIMEOUT)) u_tmo (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .clr_i    ((state_q == RD_REQ) && bus_ack_i),
    .en_i     (state_q == RD_WAIT),
    .expired_o(tmo_expired)
  );

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign words_done_o = words_q;
  assign bus_req_o    = req_q;
  assign bus_we_o     = we_q;
  assign bus_addr_bo  = addr_q;
  assign bus_be_bo    = be_q;
  assign bus_wdata_bo = wdata_q;

  // Bus fields are only ever non-zero while the matching request is live.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      words_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          err_q   <= 1'b0;
          words_q <= '0;
          if (len_i != '0) begin
            src_q   <= src_addr_i & ~32'h3;
            dst_q   <= dst_addr_i & ~32'h3;
            rem_q   <= len_i;
            busy_q  <= 1'b1;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= src_addr_i & ~32'h3;
            be_q    <= BE_FULL;
            state_q <= RD_REQ;
          end else begin
            done_q  <= 1'b1;
            state_q <= FINISH;
          end
        end
        RD_REQ: if (bus_ack_i) begin
          req_q   <= 1'b0;
          addr_q  <= '0;
          be_q    <= '0;
          state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          if (bus_resp_i) begin
            wdata_q <= bus_rdata_bi;
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= dst_q;
            be_q    <= BE_FULL;
            state_q <= WR_REQ;
          end else if (tmo_expired) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FINISH;
          end
        end
        WR_REQ: if (bus_ack_i) begin
          words_q <= words_q + LEN_WIDTH'(1);
          src_q   <= src_q + WORD_BYTES;
          dst_q   <= dst_q + WORD_BYTES;
          rem_q   <= rem_q - LEN_WIDTH'(1);
          we_q    <= 1'b0;
          wdata_q <= '0;
          if (rem_q == LEN_WIDTH'(1)) begin
            req_q   <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FINISH;
          end else begin
            addr_q  <= src_q + WORD_BYTES;
            state_q <= RD_REQ;
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
